keystream_serializer: RTL and testbench

- Sits directly downstream of the ChaCha block function.
- Captures each finished 4x4 keystream matrix when the block function pulses its serial-enable strobe.
- Buffers up to DEPTH blocks and emits them one 32-bit word per cycle over a valid/ready stream to the XOR/AEAD datapath.
- Absorbs downstream stalls, since the block function has no backpressure input; flags any block it is forced to drop.

---
 rtl/chacha_pkg.sv | 18 +
 rtl/keystream_serializer_fifo.sv | 80 ++++++++
 rtl/keystream_serializer.sv | 114 +++++++++++
 tb/tb_keystream_serializer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared ChaCha types and helpers used by the block function and the keystream serializer.
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] matrix_t;

    localparam int WORDS_PER_BLOCK = 16;

    function automatic word_t bswap32(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Word k of a row-major matrix lives at row k/4, column k%4.
    function automatic word_t matrix_word(input matrix_t m, input logic [3:0] k);
        return m[k[3:2]][k[1:0]];
    endfunction

endpackage

// File: rtl/keystream_serializer_fifo.sv
// Circular buffer of keystream blocks; decides whether an incoming block is kept or dropped.
module ks_block_fifo
    import chacha_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  matrix_t       wdata_i,
    input  logic          pop_i,
    output logic          accept_o,
    output matrix_t       head_o,
    output word_t         next_first_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          overflow_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CONE    = CW'(1);
    localparam logic [PW-1:0] PONE    = PW'(1);

    matrix_t       slots_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_next;
    logic [CW-1:0] count_q, count_d;
    logic          full_q;
    logic          overflow_q;
    logic          accept;

    // A full buffer still takes a block if the head slot is freed on the same edge.
    always_comb begin
        accept   = push_i && ((count_q != DEPTH_C) || pop_i);
        wr_ptr_d = accept ? wr_ptr_q + PONE : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PONE : rd_ptr_q;
        count_d  = count_q;
        if (accept && !pop_i) begin
            count_d = count_q + CONE;
        end else if (!accept && pop_i) begin
            count_d = count_q - CONE;
        end
        rd_next = rd_ptr_q + PONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            if (push_i && !accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slots_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign accept_o     = accept;
    assign head_o       = slots_q[rd_ptr_q];
    assign next_first_o = slots_q[rd_next][0][0];
    assign count_o      = count_q;
    assign full_o       = full_q;
    assign overflow_o   = overflow_q;

endmodule

// File: rtl/keystream_serializer.sv
// Buffers finished ChaCha keystream blocks and streams them out one word per cycle over valid/ready.
module keystream_serializer
    import chacha_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int BYTE_SWAP = 0,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  matrix_t          block_in,
    input  logic             block_valid,
    output logic [31:0]      ks_word,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic             ks_last,
    output logic [IDX_W-1:0] ks_block_idx,
    output logic             buf_full,
    output logic             overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [3:0]    LAST_WORD = 4'(WORDS_PER_BLOCK - 1);
    localparam logic [CW-1:0] CONE      = CW'(1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state_q;
    logic [3:0]       wcnt_q;
    word_t            ks_word_q;
    logic             ks_valid_q;
    logic             ks_last_q;
    logic [IDX_W-1:0] ks_block_idx_q;

    logic             pop;
    logic             accept;
    matrix_t          head;
    word_t            next_first;
    logic [CW-1:0]    count;

    function automatic word_t fmt(input word_t w);
        return (BYTE_SWAP != 0) ? bswap32(w) : w;
    endfunction

    assign pop = ks_valid_q && ks_ready && ks_last_q;

    ks_block_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (block_valid),
        .wdata_i     (block_in),
        .pop_i       (pop),
        .accept_o    (accept),
        .head_o      (head),
        .next_first_o(next_first),
        .count_o     (count),
        .full_o      (buf_full),
        .overflow_o  (overflow)
    );

    // The next word is picked one edge early so every stream output comes straight from a flop;
    // after a block ends it comes from the following slot, or from block_in when that slot is filling now.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            wcnt_q         <= '0;
            ks_word_q      <= '0;
            ks_valid_q     <= 1'b0;
            ks_last_q      <= 1'b0;
            ks_block_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= STREAM;
                        ks_valid_q <= 1'b1;
                        ks_last_q  <= 1'b0;
                        wcnt_q     <= '0;
                        ks_word_q  <= fmt(matrix_word(block_in, 4'd0));
                    end
                end
                STREAM: begin
                    if (ks_ready) begin
                        if (wcnt_q != LAST_WORD) begin
                            wcnt_q    <= wcnt_q + 4'd1;
                            ks_word_q <= fmt(matrix_word(head, wcnt_q + 4'd1));
                            ks_last_q <= (wcnt_q + 4'd1 == LAST_WORD);
                        end else begin
                            wcnt_q         <= '0;
                            ks_last_q      <= 1'b0;
                            ks_block_idx_q <= ks_block_idx_q + 1'b1;
                            if (count > CONE) begin
                                ks_word_q <= fmt(next_first);
                            end else if (accept) begin
                                ks_word_q <= fmt(matrix_word(block_in, 4'd0));
                            end else begin
                                state_q    <= IDLE;
                                ks_valid_q <= 1'b0;
                                ks_word_q  <= '0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ks_word      = ks_word_q;
    assign ks_valid     = ks_valid_q;
    assign ks_last      = ks_last_q;
    assign ks_block_idx = ks_block_idx_q;

endmodule

// File: tb/tb_keystream_serializer.sv
// Self-checking bench: scoreboard of expected keystream words plus a cycle table for the overflow case.
module tb_keystream_serializer;
    import chacha_pkg::*;

    localparam int DEPTH = 2;
    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    matrix_t          blockIn;
    logic             blockValid;
    logic             ksReady;
    logic [31:0]      ksWord;
    logic             ksValid;
    logic             ksLast;
    logic [IDX_W-1:0] ksBlockIdx;
    logic             bufFull;
    logic             overflow;

    logic [31:0]      swWord;
    logic             swValid;
    logic             swLast;
    logic [IDX_W-1:0] swBlockIdx;
    logic             swFull;
    logic             swOverflow;

    typedef struct {
        logic [31:0]      word;
        logic             last;
        logic [IDX_W-1:0] idx;
    } expEntry_t;

    typedef struct {
        logic bv;
        logic rdy;
        logic acc;
        logic expValid;
        logic expFull;
        logic expOvf;
    } vec_t;

    expEntry_t        expQ[$];
    vec_t             vecs[7];
    int               checks   = 0;
    int               errors   = 0;
    int               popCount = 0;
    logic [IDX_W-1:0] expIdx   = '0;

    always #5 clk = ~clk;

    keystream_serializer #(.DEPTH(DEPTH), .BYTE_SWAP(0), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .block_in    (blockIn),
        .block_valid (blockValid),
        .ks_word     (ksWord),
        .ks_valid    (ksValid),
        .ks_ready    (ksReady),
        .ks_last     (ksLast),
        .ks_block_idx(ksBlockIdx),
        .buf_full    (bufFull),
        .overflow    (overflow)
    );

    keystream_serializer #(.DEPTH(DEPTH), .BYTE_SWAP(1), .IDX_W(IDX_W)) dutSwap (
        .clk         (clk),
        .rst         (rst),
        .block_in    (blockIn),
        .block_valid (blockValid),
        .ks_word     (swWord),
        .ks_valid    (swValid),
        .ks_ready    (ksReady),
        .ks_last     (swLast),
        .ks_block_idx(swBlockIdx),
        .buf_full    (swFull),
        .overflow    (swOverflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fillBlock(input logic [31:0] base, input logic accepted);
        for (int k = 0; k < 16; k++) begin
            blockIn[k / 4][k % 4] = base + 32'(k);
            if (accepted) begin
                expQ.push_back('{word: base + 32'(k), last: (k == 15), idx: expIdx});
            end
        end
        if (accepted) begin
            expIdx++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base);
        fillBlock(base, 1'b1);
        blockValid = 1'b1;
        @(posedge clk);
        #1;
        blockValid = 1'b0;
    endtask

    task automatic doReset();
        rst        = 1'b0;
        blockValid = 1'b0;
        ksReady    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        expQ.delete();
        expIdx = '0;
    endtask

    task automatic drainQueue(input string name, input int maxCycles);
        int n = 0;
        ksReady = 1'b1;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
    endtask

    // Every visible word must match the queue head, which also proves stability through stalls.
    always @(negedge clk) begin
        if (rst && ksValid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got word %h, expected no valid word", ksWord);
            end else begin
                checkOutput("sb_word", ksWord, expQ[0].word);
                checkOutput("sb_last", 32'(ksLast), 32'(expQ[0].last));
                checkOutput("sb_idx", 32'(ksBlockIdx), 32'(expQ[0].idx));
                if (ksReady) begin
                    void'(expQ.pop_front());
                    popCount++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startPops;
        logic r;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        blockIn = '0;
        doReset();
        @(negedge clk);
        checkOutput("rst_valid", 32'(ksValid), 32'd0);
        checkOutput("rst_last", 32'(ksLast), 32'd0);
        checkOutput("rst_word", ksWord, 32'd0);
        checkOutput("rst_idx", 32'(ksBlockIdx), 32'd0);
        checkOutput("rst_full", 32'(bufFull), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;

        // Single block with ready held high: one word per cycle starting the cycle after the strobe.
        ksReady = 1'b1;
        applyStimulus(32'h1000_0000);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput("single_valid", 32'(ksValid), 32'd1);
            checkOutput("single_word", ksWord, 32'h1000_0000 + 32'(i));
            checkOutput("single_last", 32'(ksLast), 32'(i == 15));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("single_end_valid", 32'(ksValid), 32'd0);
        checkOutput("single_end_idx", 32'(ksBlockIdx), 32'd1);
        @(posedge clk);
        #1;

        // Reset after five words: everything clears and the next block restarts at index 0.
        ksReady = 1'b1;
        applyStimulus(32'h2000_0000);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("mid_word5", ksWord, 32'h2000_0005);
        doReset();
        @(negedge clk);
        checkOutput("mid_rst_valid", 32'(ksValid), 32'd0);
        checkOutput("mid_rst_last", 32'(ksLast), 32'd0);
        checkOutput("mid_rst_word", ksWord, 32'd0);
        checkOutput("mid_rst_idx", 32'(ksBlockIdx), 32'd0);
        checkOutput("mid_rst_full", 32'(bufFull), 32'd0);
        checkOutput("mid_rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        ksReady = 1'b1;
        applyStimulus(32'h2100_0000);
        checkOutput("mid_next_word0", ksWord, 32'h2100_0000);
        checkOutput("mid_next_idx", 32'(ksBlockIdx), 32'd0);
        drainQueue("mid_drain", 100);

        // Random stalls: each pair of cycles has exactly one ready, so no block is ever dropped.
        doReset();
        startPops = popCount;
        r = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c % 2 == 0) begin
                r = 1'($urandom_range(0, 1));
            end else begin
                r = !r;
            end
            ksReady = r;
            if (c == 0 || c == 20 || c == 40) begin
                fillBlock(32'hA000_0000 + (32'(c) << 8), 1'b1);
                blockValid = 1'b1;
            end
            @(posedge clk);
            #1;
            blockValid = 1'b0;
        end
        drainQueue("rand_drain", 200);
        checkOutput("rand_words", 32'(popCount - startPops), 32'd48);
        checkOutput("rand_ovf", 32'(overflow), 32'd0);
        checkOutput("rand_idx", 32'(ksBlockIdx), 32'd3);

        // Overflow: third block into a full buffer is dropped and only two blocks come out.
        doReset();
        startPops = popCount;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].bv) begin
                fillBlock(32'hB000_0000 + (32'(i) << 8), vecs[i].acc);
            end
            blockValid = vecs[i].bv;
            ksReady    = vecs[i].rdy;
            @(posedge clk);
            #1;
            blockValid = 1'b0;
            checkOutput("ovf_tbl_valid", 32'(ksValid), 32'(vecs[i].expValid));
            checkOutput("ovf_tbl_full", 32'(bufFull), 32'(vecs[i].expFull));
            checkOutput("ovf_tbl_ovf", 32'(overflow), 32'(vecs[i].expOvf));
        end
        drainQueue("ovf_drain", 100);
        @(negedge clk);
        checkOutput("ovf_words", 32'(popCount - startPops), 32'd32);
        checkOutput("ovf_full_after", 32'(bufFull), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        checkOutput("ovf_valid_after", 32'(ksValid), 32'd0);
        @(posedge clk);
        #1;

        // Free-and-fill: a strobe landing with the accepted last word of a full buffer is kept.
        doReset();
        applyStimulus(32'hC000_0000);
        applyStimulus(32'hC100_0000);
        checkOutput("ff_full", 32'(bufFull), 32'd1);
        ksReady = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("ff_last_shown", 32'(ksLast), 32'd1);
        fillBlock(32'hC200_0000, 1'b1);
        blockValid = 1'b1;
        @(posedge clk);
        #1;
        blockValid = 1'b0;
        checkOutput("ff_ovf", 32'(overflow), 32'd0);
        checkOutput("ff_full_kept", 32'(bufFull), 32'd1);
        checkOutput("ff_next_word", ksWord, 32'hC100_0000);
        for (int i = 0; i < 31; i++) begin
            @(posedge clk);
            #1;
            checkOutput("ff_gapless", 32'(ksValid), 32'd1);
        end
        drainQueue("ff_drain", 100);
        checkOutput("ff_ovf_end", 32'(overflow), 32'd0);

        // Byte-swapped instance sees the same block.
        doReset();
        applyStimulus(32'h0A0B_0C0D);
        checkOutput("swap_word", swWord, 32'h0D0C_0B0A);
        checkOutput("swap_valid", 32'(swValid), 32'd1);
        checkOutput("noswap_word", ksWord, 32'h0A0B_0C0D);
        drainQueue("swap_drain", 100);

        checkOutput("final_queue", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
